// File: rtl/pr_pkg.sv
// Shared types for the grant path: FSM states,
// master ids and grant-vector helpers.
package pr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [1:0] ID_A = 2'd0;
   localparam logic [1:0] ID_B = 2'd1;
   localparam logic [1:0] ID_C = 2'd2;
   localparam logic [1:0] ID_D = 2'd3;

   function automatic logic is_one_hot(
      input logic [3:0] v
   );
      return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
   endfunction

   function automatic logic is_multi(
      input logic [3:0] v
   );
      return (v != 4'b0) && !is_one_hot(v);
   endfunction

endpackage

// File: rtl/grant_burst_controller_sat_counter.sv
// Saturating up-counter with enable and
// synchronous active-high reset.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] q
);

   // Count enabled cycles, holding at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en && (q != {W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/grant_burst_controller.sv
// Turns one-hot grants into fixed-length bus
// bursts with an idle gap and service counts.
module grant_burst_controller
   import pr_pkg::*;
#(
   parameter int BURST_LEN  = 4,
   parameter int CNT_W      = 3,
   parameter int GAP_CYCLES = 1,
   parameter int SVC_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gnt_a,
   input  logic             gnt_b,
   input  logic             gnt_c,
   input  logic             gnt_d,
   output logic             bus_busy,
   output logic [1:0]       bus_owner,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             done_a,
   output logic             done_b,
   output logic             done_c,
   output logic             done_d,
   output logic             err_multi,
   output logic [SVC_W-1:0] svc_a,
   output logic [SVC_W-1:0] svc_b,
   output logic [SVC_W-1:0] svc_c,
   output logic [SVC_W-1:0] svc_d
);

   localparam int GAP_W =
      (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CNT_W-1:0] LAST_BEAT =
      CNT_W'(BURST_LEN - 1);

   localparam logic [GAP_W-1:0] LAST_GAP =
      GAP_W'(GAP_CYCLES - 1);

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic [3:0]       done_q;
   logic [3:0]       gnt;
   logic [3:0]       gnt_oh;
   logic             one_hot;
   logic             multi;
   logic [1:0]       gnt_id;
   logic             burst_end;
   logic [3:0]       svc_en;

   assign gnt     = {gnt_d, gnt_c, gnt_b, gnt_a};
   assign one_hot = is_one_hot(gnt);
   assign multi   = is_multi(gnt);

   // Only a clean one-hot vector reaches the encoder.
   assign gnt_oh = one_hot ? gnt : 4'b0001;

   // Encode the accepted grant into a master id.
   always_comb begin
      gnt_id = ID_A;
      unique case (1'b1)
         gnt_oh[0]: gnt_id = ID_A;
         gnt_oh[1]: gnt_id = ID_B;
         gnt_oh[2]: gnt_id = ID_C;
         gnt_oh[3]: gnt_id = ID_D;
         default:   gnt_id = ID_A;
      endcase
   end

   assign burst_end = (state == BURST) &&
                      (beat_cnt == LAST_BEAT);

   // Burst FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bus_busy  <= 1'b0;
         bus_owner <= 2'd0;
         beat_cnt  <= '0;
         done_q    <= 4'b0;
         err_multi <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         done_q    <= 4'b0;
         err_multi <= 1'b0;
         unique case (state)
            IDLE: begin
               if (one_hot) begin
                  state     <= BURST;
                  bus_busy  <= 1'b1;
                  bus_owner <= gnt_id;
                  beat_cnt  <= '0;
               end else if (multi) begin
                  err_multi <= 1'b1;
               end
            end
            BURST: begin
               if (beat_cnt == LAST_BEAT) begin
                  bus_busy <= 1'b0;
                  beat_cnt <= '0;
                  done_q   <= 4'b0001 << bus_owner;
                  gap_cnt  <= '0;
                  state    <= (GAP_CYCLES > 0) ?
                              GAP : IDLE;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == LAST_GAP) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done_a = done_q[0];
   assign done_b = done_q[1];
   assign done_c = done_q[2];
   assign done_d = done_q[3];

   assign svc_en = burst_end ?
                   (4'b0001 << bus_owner) : 4'b0;

   sat_counter #(.W(SVC_W)) u_svc_a (
      .clk (clk),
      .rst (rst),
      .en  (svc_en[0]),
      .q   (svc_a)
   );

   sat_counter #(.W(SVC_W)) u_svc_b (
      .clk (clk),
      .rst (rst),
      .en  (svc_en[1]),
      .q   (svc_b)
   );

   sat_counter #(.W(SVC_W)) u_svc_c (
      .clk (clk),
      .rst (rst),
      .en  (svc_en[2]),
      .q   (svc_c)
   );

   sat_counter #(.W(SVC_W)) u_svc_d (
      .clk (clk),
      .rst (rst),
      .en  (svc_en[3]),
      .q   (svc_d)
   );

endmodule

// File: tb/tb_grant_burst_controller.sv
// Bench for grant_burst_controller: three
// configurations against a timeline model.
module tb_grant_burst_controller;

   localparam int BL = 4;

   int gapv[3] = '{1, 0, 1};
   int maxv[3] = '{255, 255, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ga = 1'b0;
   logic gb = 1'b0;
   logic gc = 1'b0;
   logic gd = 1'b0;

   logic       busy_o [3];
   logic [1:0] own_o  [3];
   logic [2:0] beat_o [3];
   logic [3:0] done_o [3];
   logic       err_o  [3];
   logic [7:0] s0 [4];
   logic [7:0] s1 [4];
   logic [1:0] s2 [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   grant_burst_controller #(
      .BURST_LEN(4), .CNT_W(3),
      .GAP_CYCLES(1), .SVC_W(8)
   ) u0 (
      .clk(clk), .rst(rst),
      .gnt_a(ga), .gnt_b(gb),
      .gnt_c(gc), .gnt_d(gd),
      .bus_busy(busy_o[0]),
      .bus_owner(own_o[0]),
      .beat_cnt(beat_o[0]),
      .done_a(done_o[0][0]),
      .done_b(done_o[0][1]),
      .done_c(done_o[0][2]),
      .done_d(done_o[0][3]),
      .err_multi(err_o[0]),
      .svc_a(s0[0]), .svc_b(s0[1]),
      .svc_c(s0[2]), .svc_d(s0[3])
   );

   grant_burst_controller #(
      .BURST_LEN(4), .CNT_W(3),
      .GAP_CYCLES(0), .SVC_W(8)
   ) u1 (
      .clk(clk), .rst(rst),
      .gnt_a(ga), .gnt_b(gb),
      .gnt_c(gc), .gnt_d(gd),
      .bus_busy(busy_o[1]),
      .bus_owner(own_o[1]),
      .beat_cnt(beat_o[1]),
      .done_a(done_o[1][0]),
      .done_b(done_o[1][1]),
      .done_c(done_o[1][2]),
      .done_d(done_o[1][3]),
      .err_multi(err_o[1]),
      .svc_a(s1[0]), .svc_b(s1[1]),
      .svc_c(s1[2]), .svc_d(s1[3])
   );

   grant_burst_controller #(
      .BURST_LEN(4), .CNT_W(3),
      .GAP_CYCLES(1), .SVC_W(2)
   ) u2 (
      .clk(clk), .rst(rst),
      .gnt_a(ga), .gnt_b(gb),
      .gnt_c(gc), .gnt_d(gd),
      .bus_busy(busy_o[2]),
      .bus_owner(own_o[2]),
      .beat_cnt(beat_o[2]),
      .done_a(done_o[2][0]),
      .done_b(done_o[2][1]),
      .done_c(done_o[2][2]),
      .done_d(done_o[2][3]),
      .err_multi(err_o[2]),
      .svc_a(s2[0]), .svc_b(s2[1]),
      .svc_c(s2[2]), .svc_d(s2[3])
   );

   function automatic logic [7:0] svc_of(
      input int i, input int k
   );
      if (i == 0) return s0[k];
      if (i == 1) return s1[k];
      return {6'b0, s2[k]};
   endfunction

   task automatic chk(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   // Timeline model: a burst accepted at edge n
   // is busy after edges n..n+BL-1, completes at
   // n+BL, and the next grant is seen at
   // n+BL+GAP+1.
   longint cyc = 0;
   longint start_c[3] = '{-100, -100, -100};
   longint free_c[3]  = '{0, 0, 0};
   int     own_m[3]   = '{0, 0, 0};
   int     svc_m[3][4];
   bit     err_m[3]   = '{0, 0, 0};
   bit     armed      = 1'b0;

   always @(posedge clk) begin : model
      logic [3:0] g;
      int         pc;
      int         id;
      g  = {gd, gc, gb, ga};
      pc = $countones(g);
      id = 0;
      for (int k = 0; k < 4; k++)
         if (g[k]) id = k;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            start_c[i] = -100;
            free_c[i]  = cyc + 1;
            own_m[i]   = 0;
            err_m[i]   = 1'b0;
            for (int k = 0; k < 4; k++)
               svc_m[i][k] = 0;
         end else begin
            err_m[i] = 1'b0;
            if (cyc == start_c[i] + BL &&
                svc_m[i][own_m[i]] < maxv[i])
               svc_m[i][own_m[i]]++;
            if (cyc >= free_c[i]) begin
               if (pc == 1) begin
                  start_c[i] = cyc;
                  own_m[i]   = id;
                  free_c[i]  = cyc + BL + gapv[i] + 1;
               end else if (pc > 1) begin
                  err_m[i] = 1'b1;
               end
            end
         end
      end
      if (rst) armed = 1'b1;
   end

   // Per-cycle comparison of every output.
   always @(negedge clk) begin : compare
      bit         eb;
      int         ebeat;
      logic [3:0] ed;
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            eb = (cyc >= start_c[i]) &&
                 (cyc < start_c[i] + BL);
            ebeat = eb ? int'(cyc - start_c[i]) : 0;
            ed = (cyc == start_c[i] + BL) ?
                 (4'b0001 << own_m[i]) : 4'b0;
            chk($sformatf("u%0d busy", i),
                32'(busy_o[i]), 32'(eb));
            chk($sformatf("u%0d owner", i),
                32'(own_o[i]), own_m[i]);
            chk($sformatf("u%0d beat", i),
                32'(beat_o[i]), ebeat);
            chk($sformatf("u%0d done", i),
                32'(done_o[i]), 32'(ed));
            chk($sformatf("u%0d err", i),
                32'(err_o[i]), 32'(err_m[i]));
            for (int k = 0; k < 4; k++)
               chk($sformatf("u%0d svc%0d", i, k),
                   32'(svc_of(i, k)), svc_m[i][k]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk({tag, " busy"}, 32'(busy_o[i]), 0);
         chk({tag, " owner"}, 32'(own_o[i]), 0);
         chk({tag, " beat"}, 32'(beat_o[i]), 0);
         chk({tag, " done"}, 32'(done_o[i]), 0);
         chk({tag, " err"}, 32'(err_o[i]), 0);
         for (int k = 0; k < 4; k++)
            chk({tag, " svc"}, 32'(svc_of(i, k)), 0);
      end
   endtask

   int sat_exp[5] = '{1, 2, 3, 3, 3};

   initial begin : stim
      logic [3:0] r4;
      int         sel;
      // reset with random grants
      for (int n = 0; n < 5; n++) begin
         r4 = 4'($urandom);
         {gd, gc, gb, ga} = r4;
         tick();
         chk_zero("reset");
      end
      rst = 1'b0;
      {gd, gc, gb, ga} = 4'b0;
      tick();

      // single burst for master b
      gb = 1'b1;
      tick();
      gb = 1'b0;
      chk("b busy0", 32'(busy_o[0]), 1);
      chk("b owner", 32'(own_o[0]), 1);
      chk("b beat0", 32'(beat_o[0]), 0);
      for (int b = 1; b < 4; b++) begin
         tick();
         chk("b busy", 32'(busy_o[0]), 1);
         chk("b beat", 32'(beat_o[0]), b);
      end
      tick();
      chk("b busy end", 32'(busy_o[0]), 0);
      chk("b done", 32'(done_o[0]), 4'b0010);
      chk("b svc", 32'(s0[1]), 1);
      ga = 1'b1;
      tick();
      chk("gap ignore", 32'(busy_o[0]), 0);
      chk("gap0 accept", 32'(busy_o[1]), 1);
      tick();
      chk("gap accept", 32'(busy_o[0]), 1);
      chk("gap owner", 32'(own_o[0]), 0);
      ga = 1'b0;
      repeat (8) tick();

      // two grants in IDLE
      ga = 1'b1;
      gc = 1'b1;
      tick();
      ga = 1'b0;
      gc = 1'b0;
      chk("multi err", 32'(err_o[0]), 1);
      chk("multi busy", 32'(busy_o[0]), 0);
      chk("multi svc a", 32'(s0[0]), 1);
      chk("multi svc c", 32'(s0[2]), 0);
      tick();
      chk("multi pulse", 32'(err_o[0]), 0);
      repeat (3) tick();

      // continuous d grant
      gd = 1'b1;
      repeat (46) tick();
      gd = 1'b0;
      repeat (12) tick();
      chk("held d gap0", 32'(s1[3]), 10);
      chk("held d gap1", 32'(s0[3]), 8);
      chk("held d sat", 32'(s2[3]), 3);

      // reset mid-burst
      ga = 1'b1;
      tick();
      ga = 1'b0;
      tick();
      tick();
      chk("abort beat", 32'(beat_o[0]), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("abort");
      repeat (4) begin
         tick();
         chk("abort done", 32'(done_o[0]), 0);
         chk("abort svc", 32'(s0[0]), 0);
      end

      // saturation on a 2-bit counter
      for (int n = 0; n < 5; n++) begin
         gc = 1'b1;
         tick();
         gc = 1'b0;
         repeat (4) tick();
         chk("sat svc c", 32'(s2[2]), sat_exp[n]);
         repeat (2) tick();
      end

      // random resolver-like grant stream
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 5)
            r4 = 4'b0001 << $urandom_range(0, 3);
         else if (sel < 8)
            r4 = 4'b0;
         else
            r4 = 4'($urandom);
         {gd, gc, gb, ga} = r4;
         tick();
      end
      rst = 1'b0;
      {gd, gc, gb, ga} = 4'b0;
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
